// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light request front-end.
package traffic_pkg;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StPending = 2'd1;
  localparam logic [1:0] StServing = 2'd2;

  localparam int unsigned DefDebounceCycles = 4;
  localparam int unsigned DefCntW           = 4;

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a hold-time debouncer for one raw input.
module debounce_sync #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic db_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // Any return of s2 to the accepted level restarts the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      db_d  = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/traffic_request_front.sv
// Debounced car sensor and latched pedestrian walk request for traffic_light.
module traffic_request_front
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned CNT_W           = DefCntW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_raw,
  input  logic       walk_raw,
  input  logic       walkLight,
  output logic       Sensor,
  output logic       walkButton,
  output logic [1:0] req_state
);

  logic sensor_db;
  logic walk_db;
  logic walk_db_q;
  logic press;

  logic [1:0] state_q, state_d;
  logic       rearm_q, rearm_d;
  logic       walk_button_q;

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_sensor_db (
    .clk  (clk),
    .rst  (rst),
    .raw_i(sensor_raw),
    .db_o (sensor_db)
  );

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_walk_db (
    .clk  (clk),
    .rst  (rst),
    .raw_i(walk_raw),
    .db_o (walk_db)
  );

  assign press = walk_db & ~walk_db_q;

  always_comb begin
    state_d = state_q;
    rearm_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (press) state_d = StPending;
      end
      StPending: begin
        // Presses here are absorbed; the request is already held.
        if (walkLight) state_d = StServing;
      end
      StServing: begin
        if (!walkLight) begin
          state_d = (rearm_q || press) ? StPending : StIdle;
        end else begin
          rearm_d = rearm_q | press;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      walk_db_q     <= 1'b0;
      state_q       <= StIdle;
      rearm_q       <= 1'b0;
      walk_button_q <= 1'b0;
    end else begin
      walk_db_q     <= walk_db;
      state_q       <= state_d;
      rearm_q       <= rearm_d;
      walk_button_q <= (state_d == StPending);
    end
  end

  assign Sensor     = sensor_db;
  assign walkButton = walk_button_q;
  assign req_state  = state_q;

endmodule

// File: tb/tb_traffic_request_front.sv
// Directed bench for traffic_request_front at DEBOUNCE_CYCLES=4, 10 ns clock.
module tb_traffic_request_front;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sensor_raw = 1'b0;
  logic       walk_raw = 1'b0;
  logic       walkLight = 1'b0;
  logic       Sensor;
  logic       walkButton;
  logic [1:0] req_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  traffic_request_front #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sensor_raw(sensor_raw),
    .walk_raw  (walk_raw),
    .walkLight (walkLight),
    .Sensor    (Sensor),
    .walkButton(walkButton),
    .req_state (req_state)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a press and stop right after the edge where the button db rises.
  task automatic press_to_event();
    walk_raw = 1'b1;
    tick(6);
  endtask

  // Release and wait until the button db is back to 0.
  task automatic release_button();
    walk_raw = 1'b0;
    tick(8);
  endtask

  initial begin
    // 1. Reset behaviour
    tick(10);
    check("rst_sensor", {7'd0, Sensor}, 8'd0);
    check("rst_walkbtn", {7'd0, walkButton}, 8'd0);
    check("rst_state", {6'd0, req_state}, 8'd0);
    rst = 1'b1;
    tick(10);
    check("idle_sensor", {7'd0, Sensor}, 8'd0);
    check("idle_walkbtn", {7'd0, walkButton}, 8'd0);
    check("idle_state", {6'd0, req_state}, 8'd0);

    press_to_event();
    check("pre_pend_state", {6'd0, req_state}, 8'd0);
    tick(1);
    check("pend_state", {6'd0, req_state}, 8'd1);
    check("pend_walkbtn", {7'd0, walkButton}, 8'd1);
    walk_raw = 1'b0;
    #4;
    rst = 1'b0;
    #1;
    check("async_rst_walkbtn", {7'd0, walkButton}, 8'd0);
    check("async_rst_state", {6'd0, req_state}, 8'd0);
    tick(2);
    rst = 1'b1;
    tick(3);
    check("post_rst_state", {6'd0, req_state}, 8'd0);

    // 2. Sensor latency, both directions
    sensor_raw = 1'b1;
    tick(5);
    check("sensor_rise_e5", {7'd0, Sensor}, 8'd0);
    tick(1);
    check("sensor_rise_e6", {7'd0, Sensor}, 8'd1);
    tick(14);
    check("sensor_hold", {7'd0, Sensor}, 8'd1);
    sensor_raw = 1'b0;
    tick(5);
    check("sensor_fall_e5", {7'd0, Sensor}, 8'd1);
    tick(1);
    check("sensor_fall_e6", {7'd0, Sensor}, 8'd0);

    // 3. Bounce rejection
    walk_raw = 1'b1;
    tick(3);
    walk_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("pulse_walkbtn", {7'd0, walkButton}, 8'd0);
    end
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) walk_raw = ~walk_raw;
      tick(1);
      check("bounce_walkbtn", {7'd0, walkButton}, 8'd0);
      check("bounce_state", {6'd0, req_state}, 8'd0);
    end
    release_button();
    check("bounce_end_state", {6'd0, req_state}, 8'd0);

    // 4. Clean press, serve, clear
    walkLight = 1'b1;
    tick(2);
    check("idle_ignores_light", {6'd0, req_state}, 8'd0);
    walkLight = 1'b0;
    walk_raw = 1'b1;
    tick(6);
    check("press_e6_walkbtn", {7'd0, walkButton}, 8'd0);
    tick(1);
    check("press_e7_walkbtn", {7'd0, walkButton}, 8'd1);
    tick(3);
    walk_raw = 1'b0;
    check("press_hold_state", {6'd0, req_state}, 8'd1);
    walkLight = 1'b1;
    tick(1);
    check("serve_walkbtn", {7'd0, walkButton}, 8'd0);
    check("serve_state", {6'd0, req_state}, 8'd2);
    tick(8);
    walkLight = 1'b0;
    tick(1);
    check("clear_state", {6'd0, req_state}, 8'd0);

    // 5. Rearm during SERVING, absorb during PENDING
    press_to_event();
    tick(1);
    check("p5_pend", {6'd0, req_state}, 8'd1);
    release_button();
    press_to_event();
    tick(1);
    check("p5_absorb_state", {6'd0, req_state}, 8'd1);
    release_button();
    walkLight = 1'b1;
    tick(1);
    check("p5_serve", {6'd0, req_state}, 8'd2);
    press_to_event();
    tick(1);
    release_button();
    walkLight = 1'b0;
    tick(1);
    check("rearm_state", {6'd0, req_state}, 8'd1);
    check("rearm_walkbtn", {7'd0, walkButton}, 8'd1);
    walkLight = 1'b1;
    tick(1);
    check("rearm_serve", {6'd0, req_state}, 8'd2);
    walkLight = 1'b0;
    tick(1);
    check("single_service", {6'd0, req_state}, 8'd0);
    tick(3);
    check("single_service_hold", {6'd0, req_state}, 8'd0);

    // 6. Simultaneous events
    press_to_event();
    tick(1);
    release_button();
    check("sim_pend", {6'd0, req_state}, 8'd1);
    press_to_event();
    walkLight = 1'b1;
    tick(1);
    check("sim_rise_state", {6'd0, req_state}, 8'd2);
    walk_raw = 1'b0;
    walkLight = 1'b0;
    tick(1);
    check("sim_rise_no_rearm", {6'd0, req_state}, 8'd0);
    tick(7);
    press_to_event();
    tick(1);
    release_button();
    walkLight = 1'b1;
    tick(1);
    check("sim_fall_serve", {6'd0, req_state}, 8'd2);
    press_to_event();
    walkLight = 1'b0;
    tick(1);
    check("sim_fall_state", {6'd0, req_state}, 8'd1);
    check("sim_fall_walkbtn", {7'd0, walkButton}, 8'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_request_front.md
# traffic_request_front

Input front-end that produces the `Sensor` and `walkButton` request signals consumed by `traffic_light`. It closes the loop on the walk light.
- Raw, asynchronous, bouncy inputs from the side-street car sensor and the pedestrian push-button are synchronized and debounced.
- A pedestrian press is latched as a held request until `traffic_light` serves it.
- A request is served when `walkLight` rises and then falls.
- Sits between the board I/O pins and `traffic_light`, in the same clock domain.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized cycles an input must hold a new level before it is accepted. Legal range is 2..2^CNT_W-1.
- `CNT_W`, default 4: debounce counter width.
- `clk` input, 1 bit: system clock, the same clock as `traffic_light`.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `sensor_raw` input, 1 bit: raw car sensor, asynchronous to `clk`.
- `walk_raw` input, 1 bit: raw pedestrian button, asynchronous to `clk`, active-high.
- `walkLight` input, 1 bit: walk light from `traffic_light`. It is synchronous to `clk` and is used without a synchronizer.
- `Sensor` output, 1 bit: debounced sensor level.
- `walkButton` output, 1 bit: held walk request, high only in the PENDING state.
- `req_state` output, 2 bits: walk FSM state, for debug.

## Operation
- **Debouncer** (one instance per raw input):
  - A 2-FF synchronizer produces `s2`. The accepted level is `db`, and the counter is `cnt`.
  - If `s2 == db`, `cnt` is cleared to 0.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`, then `db <= s2` and `cnt <= 0`.
  - Otherwise `cnt <= cnt + 1`.
  - Any return of `s2` to `db` restarts the count, so bounce shorter than `DEBOUNCE_CYCLES` never propagates.
- `Sensor` is the sensor debouncer's `db`, driven straight from a register.
- A press event is a rising edge of the button `db`, i.e. `db & ~db_q`, where `db_q` is `db` delayed by one cycle.
- **Walk FSM states:** IDLE=0, PENDING=1, SERVING=2. Encoding 3 is illegal and recovers to IDLE.
- IDLE:
  - On a press event, go to PENDING.
  - A `walkLight` high level while in IDLE is ignored.
- PENDING:
  - When `walkLight==1`, go to SERVING.
  - Further press events are absorbed, so there is no double request.
- SERVING:
  - A press event sets the `rearm` flag.
  - When `walkLight==0`: go to PENDING if `rearm` is set, otherwise go to IDLE.
  - `rearm` is cleared on leaving SERVING.
- Simultaneous events:
  - A press event and `walkLight` rising in the same cycle while in PENDING: the FSM goes to SERVING and the press is absorbed.
  - A press event and `walkLight` falling in the same cycle while in SERVING: the FSM goes to PENDING.
- `walkButton` is the registered decode `state==PENDING`.
- Reset mid-operation clears any pending request, `rearm`, and all debounce state immediately.

## Timing
- Reset values: `Sensor=0`, `walkButton=0`, `req_state=0`, `db=0`, `cnt=0`, `rearm=0`, synchronizer flops 0.
- Raw-to-`db` latency: `db` changes on the (`DEBOUNCE_CYCLES`+2)th rising edge, counting the first edge that samples the new stable raw level as edge 1. With the default of 4, that is edge 6.
- `Sensor` changes on the same edge as `db`.
- `walkButton` rises one edge after the button `db` rises, i.e. edge `DEBOUNCE_CYCLES`+3 (7 at the default).
- The PENDING to SERVING transition, and the resulting fall of `walkButton`, happen on the first edge at which `walkLight==1` is sampled.
- SERVING exit happens on the first edge at which `walkLight==0` is sampled.
- Release of the button has no effect on the FSM.

## Structure
- Shared package `traffic_pkg`: the walk FSM state localparams (IDLE, PENDING, SERVING) and the default `DEBOUNCE_CYCLES`.
- Sub-module `debounce_sync`: synchronizer plus counter, parameterized by `DEBOUNCE_CYCLES` and `CNT_W`, instantiated twice.
- The top level holds the edge detect, the FSM and `rearm`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and a 10 ns clock.
1. Hold `rst=0` for 10 cycles, then release → all outputs stay 0 with no raw activity. Assert `rst=0` asynchronously mid-cycle while in PENDING → `walkButton=0` and `req_state=0` before the next clock edge.
2. `sensor_raw` 0→1, held for 20 cycles → `Sensor` rises on edge 6. Then 0 → `Sensor` falls 6 edges later.
3. `walk_raw` pulses high for 3 cycles, and also toggles every 2 cycles for 30 cycles → `walkButton` never asserts and `req_state` stays 0.
4. Clean press held for 10 cycles → `walkButton=1` from edge 7. Drive `walkLight=1` → `walkButton=0` and `req_state=2` on the next edge. Drive `walkLight=0` → `req_state=0`.
5. A second press while `walkLight=1` (SERVING) → on `walkLight` falling, `req_state=1` and `walkButton=1`. A press while PENDING → still a single request, serviced once.
6. A press event and `walkLight` rising in the same cycle from PENDING → `req_state=2` with `rearm=0`. A press event and `walkLight` falling in the same cycle → `req_state=1`.
